// File: rtl/event_stat_serializer.sv
// Snapshots packed event statistics into a shadow register and streams them out
// as a framed sequence of 32-bit words: one header, then one word per peak counter.
module event_stat_serializer #(
   parameter int NUM_PEAK = 4,
   parameter int PEAK_W   = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       snap_req,
   input  logic [NUM_PEAK*PEAK_W-1:0] stat_in,
   output logic [31:0]                m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic                       m_last,
   output logic                       busy,
   output logic                       overrun,
   output logic [15:0]                frame_cnt
);

   localparam int STAT_W = NUM_PEAK * PEAK_W;
   localparam int IDX_W  = (NUM_PEAK > 1) ? $clog2(NUM_PEAK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_PEAK - 1);
   localparam logic [7:0]       NUM_PEAK_B = 8'(NUM_PEAK);
   localparam logic [7:0]       HDR_TAG    = 8'hA5;

   typedef enum logic [1:0] {ST_IDLE, ST_HDR, ST_DATA} state_t;

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [STAT_W-1:0] shadow_q, shadow_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic              overrun_q, overrun_d;
   logic [31:0]       m_data_q, m_data_d;
   logic              m_valid_q, m_valid_d;
   logic              m_last_q, m_last_d;

   logic [31:0]       peak_words [NUM_PEAK];
   logic              handshake;
   logic              last_hs;
   logic              accept;
   logic [IDX_W-1:0]  idx_next;

   // Zero-extended view of each shadowed peak counter.
   for (genvar gi = 0; gi < NUM_PEAK; gi++) begin : g_peak
      assign peak_words[gi] = 32'(shadow_q[gi*PEAK_W +: PEAK_W]);
   end

   assign handshake = m_valid_q & m_ready;
   assign last_hs   = handshake && (state_q == ST_DATA) && (idx_q == LAST_IDX);
   assign accept    = snap_req && ((state_q == ST_IDLE) || last_hs);
   assign idx_next  = idx_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      frame_cnt_d = frame_cnt_q;
      overrun_d   = overrun_q;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;

      if (snap_req && !accept) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         ST_HDR: begin
            if (handshake) begin
               state_d  = ST_DATA;
               idx_d    = '0;
               m_data_d = peak_words[0];
               m_last_d = (NUM_PEAK == 1);
            end
         end
         ST_DATA: begin
            if (handshake) begin
               if (idx_q != LAST_IDX) begin
                  idx_d    = idx_next;
                  m_data_d = peak_words[idx_next];
                  m_last_d = (idx_next == LAST_IDX);
               end else begin
                  state_d   = ST_IDLE;
                  idx_d     = '0;
                  m_data_d  = '0;
                  m_valid_d = 1'b0;
                  m_last_d  = 1'b0;
               end
            end
         end
         default: ;
      endcase

      // An accepted snapshot overrides the end-of-frame teardown so frames abut.
      if (accept) begin
         state_d     = ST_HDR;
         idx_d       = '0;
         shadow_d    = stat_in;
         frame_cnt_d = frame_cnt_q + 16'd1;
         m_data_d    = {HDR_TAG, NUM_PEAK_B, frame_cnt_q};
         m_valid_d   = 1'b1;
         m_last_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         shadow_q    <= '0;
         frame_cnt_q <= '0;
         overrun_q   <= 1'b0;
         m_data_q    <= '0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         shadow_q    <= shadow_d;
         frame_cnt_q <= frame_cnt_d;
         overrun_q   <= overrun_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
      end
   end

   assign m_data    = m_data_q;
   assign m_valid   = m_valid_q;
   assign m_last    = m_last_q;
   assign busy      = (state_q != ST_IDLE);
   assign overrun   = overrun_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: doc/event_stat_serializer.md
Name: event_stat_serializer

Overview:
- Transmit side for event statistics: snapshots a packed event_stat_struct (struct_test_pkg) and streams it out as 32-bit words over a valid/ready stream.
- Each frame is one header word followed by one word per peak counter.
- Sits after the statistics accumulator and feeds a host-facing stream, e.g. AXI-Stream to DMA.
- The shadow copy decouples the live stats, which keep counting, from the transmitted frame.

Parameters:
- NUM_PEAK, 4, number of peak counters in the struct (1..255).
- PEAK_W, 16, width of each peak counter (1..32).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- snap_req  in  1  single-cycle request to capture stat_in and send one frame.
- stat_in  in  NUM_PEAK*PEAK_W  packed stats; peak[i] = stat_in[i*PEAK_W +: PEAK_W].
- m_data  out  32  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready from sink.
- m_last  out  1  high on the final word of a frame.
- busy  out  1  frame capture or transmission in progress.
- overrun  out  1  sticky flag: a snap_req was dropped; cleared only by reset.
- frame_cnt  out  16  count of accepted snapshots; wraps 0xFFFF->0x0000.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_data=0, busy=0, overrun=0, frame_cnt=0, FSM=IDLE, seq=0, shadow=0.
- Reset is checked before all other logic. Reset mid-frame abandons the frame; m_valid is 0 the cycle after the reset edge, and no partial frame resumes.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - snap_req=1 latches stat_in into the shadow register and increments frame_cnt.
  - The header word is loaded; next state is HDR.
  - m_valid=1 on the cycle after snap_req (latency 1).
- Header word: bits [31:24]=0xA5, [23:16]=NUM_PEAK, [15:0]=seq, where seq is the frame_cnt value before the increment. The first frame carries seq=0.
- HDR: on handshake (m_valid & m_ready) go to DATA with idx=0 and m_data = shadow peak[0], zero-extended to 32 bits.
- DATA: on handshake, if idx < NUM_PEAK-1, increment idx and present peak[idx+1].
- m_last=1 exactly while the word for peak[NUM_PEAK-1] is presented.
- A handshake on the last word ends the frame: next state is IDLE and m_valid drops the next cycle, unless the back-to-back case below applies.
- Stream rules:
  - Once m_valid=1, m_data, m_last and m_valid hold stable until the handshake.
  - m_valid never depends combinationally on m_ready.
  - m_ready may stall for any number of cycles on any word.
- busy = (state != IDLE).
- snap_req while busy and not on the final handshake cycle:
  - The request is dropped and overrun is set.
  - The shadow register, frame_cnt and the frame in flight are unaffected.
- Back-to-back: snap_req in the same cycle as the last-word handshake is accepted.
  - The shadow is recaptured and the next header is presented the following cycle.
  - m_valid stays 1 with no gap; overrun is not set.
- stat_in is sampled only on an accepted snap_req. Later changes to stat_in never alter a frame in flight.
- Frame length is always NUM_PEAK+1 words. Minimum frame period is NUM_PEAK+1 cycles with m_ready held at 1.

Test Plan:
- Basic frame, reset released, m_ready=1: stat_in peaks {0x0001,0x0002,0x0003,0x0004}, snap_req pulse at cycle T. Required: words 0xA5040000, 0x1, 0x2, 0x3, 0x4 on cycles T+1..T+5; m_last only on 0x4; busy=0 at T+6; frame_cnt=1.
- Backpressure: m_ready toggles 1,0,0,1,... while stat_in increments every cycle after snap. Required: data held stable during stalls; frame carries only the captured values; word count 5.
- Overrun: snap_req at T and again at T+2 (mid-frame). Required: single frame emitted; overrun=1 from T+3; frame_cnt=1; next header seq=1.
- Back-to-back: second snap_req in the cycle of the last-word handshake. Required: second header 0xA5040001 on the next cycle; m_valid never low between frames; overrun=0.
- Reset mid-frame: assert reset during the DATA word for peak[1]. Required: m_valid=0 and busy=0 after the reset edge; frame_cnt=0; next snap emits seq=0.
- Wrap: force 65536 frames (or preload frame_cnt in the bench). Required: header seq 0xFFFF followed by 0x0000; frame_cnt wraps to 0x0000.
